// File: rtl/fft_pkg.sv
// Shared FFT scheduler types and helpers: FSM state encoding, pipeline latency,
// bit reversal and radix-2 butterfly address arithmetic.
package fft_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FLUSH,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  // One ROM/RAM read cycle plus the shared multiplier and adder pipelines.
  function automatic int unsigned pipe_lat(input int unsigned mul_lat, input int unsigned add_lat);
    return 32'd1 + mul_lat + add_lat;
  endfunction

  function automatic int unsigned bitrev(input int unsigned k, input int unsigned width);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < width; i++) begin
      if (k[i]) r = r | (32'd1 << (width - 32'd1 - i));
    end
    return r;
  endfunction

  // Lower operand address of butterfly j in stage s (span 2^s).
  function automatic int unsigned bfly_a(input int unsigned j, input int unsigned s);
    return ((j >> s) << (s + 32'd1)) | (j & ((32'd1 << s) - 32'd1));
  endfunction

  function automatic int unsigned bfly_tw(input int unsigned j, input int unsigned s,
                                          input int unsigned log2n);
    return (j & ((32'd1 << s) - 32'd1)) << (log2n - 32'd1 - s);
  endfunction

endpackage

// File: rtl/fft_sched_dly.sv
// Valid + address-pair shift register aligning write-back with issue.
module fft_sched_dly #(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned AW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [AW-1:0] in_a,
  input  logic [AW-1:0] in_b,
  output logic          out_valid,
  output logic [AW-1:0] out_a,
  output logic [AW-1:0] out_b
);

  logic [DEPTH-1:0] v;
  logic [AW-1:0]    a [DEPTH];
  logic [AW-1:0]    b [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst) begin
      v <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        a[i] <= '0;
        b[i] <= '0;
      end
    end else begin
      v[0] <= in_valid;
      a[0] <= in_a;
      b[0] <= in_b;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        v[i] <= v[i-1];
        a[i] <= a[i-1];
        b[i] <= b[i-1];
      end
    end
  end

  assign out_valid = v[DEPTH-1];
  assign out_a     = a[DEPTH-1];
  assign out_b     = b[DEPTH-1];

endmodule

// File: rtl/fft_sched.sv
// In-place radix-2 FFT address/control scheduler: load, per-stage butterfly issue, drain.
// Define FFT_SCHED_BITREV_EN to bit-reverse the load write address.
module fft_sched
  import fft_pkg::*;
#(
  parameter int unsigned LOG2N   = 8,
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned ADD_LAT = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [LOG2N-1:0] addr_i,
  output logic             load_we,
  output logic [LOG2N-1:0] load_addr,
  output logic [LOG2N-1:0] rd_addr_a,
  output logic [LOG2N-1:0] rd_addr_b,
  output logic [LOG2N-2:0] tw_addr,
  output logic             issue,
  output logic             wr_en,
  output logic [LOG2N-1:0] wr_addr_a,
  output logic [LOG2N-1:0] wr_addr_b,
  output logic [3:0]       stage
);

  localparam int unsigned N        = 32'd1 << LOG2N;
  localparam int unsigned HALF_N   = N / 32'd2;
  localparam int unsigned PIPE_LAT = pipe_lat(MUL_LAT, ADD_LAT);
  localparam int unsigned DW       = $clog2(PIPE_LAT) + 1;
  localparam int unsigned TW       = LOG2N - 1;

  state_t           state;
  logic [LOG2N-1:0] cnt;
  logic [DW-1:0]    dcnt;
  logic             ld_valid;
  logic [LOG2N-1:0] load_map;

  logic             iss_next;
  int unsigned      j_next;
  int unsigned      s_next;

  always_comb begin
`ifdef FFT_SCHED_BITREV_EN
    load_map = LOG2N'(bitrev(32'(addr_i), LOG2N));
`else
    load_map = addr_i;
`endif
  end

  // The butterfly for the following cycle is chosen here so the issue
  // outputs can be registered alongside the state transition.
  always_comb begin
    iss_next = 1'b0;
    j_next   = 0;
    s_next   = 32'(stage);
    case (state)
      FLUSH: begin
        iss_next = 1'b1;
        s_next   = 0;
      end
      ISSUE: begin
        if (cnt != LOG2N'(HALF_N - 1)) begin
          iss_next = 1'b1;
          j_next   = 32'(cnt) + 32'd1;
        end
      end
      DRAIN: begin
        if (dcnt == DW'(PIPE_LAT - 1) && stage != 4'(LOG2N - 1)) begin
          iss_next = 1'b1;
          s_next   = 32'(stage) + 32'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      dcnt      <= '0;
      ld_valid  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      addr_i    <= '0;
      load_we   <= 1'b0;
      load_addr <= '0;
      issue     <= 1'b0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      tw_addr   <= '0;
      stage     <= '0;
    end else begin
      issue     <= iss_next;
      rd_addr_a <= iss_next ? LOG2N'(bfly_a(j_next, s_next)) : '0;
      rd_addr_b <= iss_next ? LOG2N'(bfly_a(j_next, s_next) + (32'd1 << s_next)) : '0;
      tw_addr   <= iss_next ? TW'(bfly_tw(j_next, s_next, LOG2N)) : '0;
      load_we   <= ld_valid;
      load_addr <= ld_valid ? load_map : '0;
      done      <= 1'b0;
      addr_i    <= '0;
      ld_valid  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= LOAD;
            busy     <= 1'b1;
            cnt      <= '0;
            ld_valid <= 1'b1;
          end
        end
        LOAD: begin
          if (cnt == LOG2N'(N - 1)) begin
            state <= FLUSH;
          end else begin
            cnt      <= cnt + 1'b1;
            addr_i   <= cnt + 1'b1;
            ld_valid <= 1'b1;
          end
        end
        FLUSH: begin
          state <= ISSUE;
          stage <= '0;
          cnt   <= '0;
        end
        ISSUE: begin
          if (cnt == LOG2N'(HALF_N - 1)) begin
            state <= DRAIN;
            dcnt  <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (dcnt == DW'(PIPE_LAT - 1)) begin
            if (stage == 4'(LOG2N - 1)) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              stage <= '0;
            end else begin
              state <= ISSUE;
              stage <= stage + 1'b1;
              cnt   <= '0;
            end
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  fft_sched_dly #(
    .DEPTH(PIPE_LAT),
    .AW   (LOG2N)
  ) u_dly (
    .clk      (clk),
    .rst      (rst),
    .in_valid (issue),
    .in_a     (rd_addr_a),
    .in_b     (rd_addr_b),
    .out_valid(wr_en),
    .out_a    (wr_addr_a),
    .out_b    (wr_addr_b)
  );

endmodule

// File: tb/tb_fft_sched.sv
// Bench for fft_sched at N=8, MUL_LAT=1, ADD_LAT=1 against a cycle-indexed schedule model.
module tb_fft_sched;

  localparam int L      = 3;
  localparam int N      = 1 << L;
  localparam int P      = 3;
  localparam int DONE_T = N + 2 + L * (N / 2 + P);

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       load_we;
    logic       issue;
    logic       wr_en;
    logic [3:0] stage;
    logic [2:0] addr_i;
    logic [2:0] load_addr;
    logic [2:0] rd_a;
    logic [2:0] rd_b;
    logic [1:0] tw;
    logic [2:0] wr_a;
    logic [2:0] wr_b;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       busy, done, load_we, issue, wr_en;
  logic [2:0] addr_i, load_addr, rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [1:0] tw_addr;
  logic [3:0] stage;
  obs_t       obs;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  fft_sched #(
    .LOG2N  (L),
    .MUL_LAT(1),
    .ADD_LAT(1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .addr_i   (addr_i),
    .load_we  (load_we),
    .load_addr(load_addr),
    .rd_addr_a(rd_addr_a),
    .rd_addr_b(rd_addr_b),
    .tw_addr  (tw_addr),
    .issue    (issue),
    .wr_en    (wr_en),
    .wr_addr_a(wr_addr_a),
    .wr_addr_b(wr_addr_b),
    .stage    (stage)
  );

  always_comb begin
    obs           = '0;
    obs.busy      = busy;
    obs.done      = done;
    obs.load_we   = load_we;
    obs.issue     = issue;
    obs.wr_en     = wr_en;
    obs.stage     = stage;
    obs.addr_i    = addr_i;
    obs.load_addr = load_addr;
    obs.rd_a      = rd_addr_a;
    obs.rd_b      = rd_addr_b;
    obs.tw        = tw_addr;
    obs.wr_a      = wr_addr_a;
    obs.wr_b      = wr_addr_b;
  end

  function automatic int map_k(input int k);
`ifdef FFT_SCHED_BITREV_EN
    int r;
    r = 0;
    for (int i = 0; i < L; i++) if (((k >> i) & 1) == 1) r = r + (1 << (L - 1 - i));
    return r;
`else
    return k;
`endif
  endfunction

  // Expected outputs at cycle t, where cycle 0 is the IDLE cycle that samples start.
  function automatic obs_t expect_at(input int t);
    obs_t e;
    int   base, half, a;
    e = '0;
    if (t >= 1 && t <= N) e.addr_i = 3'(t - 1);
    if (t >= 1 && t < DONE_T) e.busy = 1'b1;
    if (t == DONE_T) e.done = 1'b1;
    if (t >= 2 && t <= N + 1) begin
      e.load_we   = 1'b1;
      e.load_addr = 3'(map_k(t - 2));
    end
    for (int s = 0; s < L; s++) begin
      base = N + 2 + s * (N / 2 + P);
      half = 1 << s;
      if (t >= base && t < base + N / 2 + P) e.stage = 4'(s);
      for (int j = 0; j < N / 2; j++) begin
        a = (j / half) * 2 * half + (j % half);
        if (t == base + j) begin
          e.issue = 1'b1;
          e.rd_a  = 3'(a);
          e.rd_b  = 3'(a + half);
          e.tw    = 2'((j % half) << (L - 1 - s));
        end
        if (t == base + j + P) begin
          e.wr_en = 1'b1;
          e.wr_a  = 3'(a);
          e.wr_b  = 3'(a + half);
        end
      end
    end
    return e;
  endfunction

  task automatic check(input obs_t e, input string tag);
    n_checks++;
    assert (obs === e) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, e);
  endtask

  // One transform; start toggles randomly while busy and takes start_at_done in DONE.
  task automatic transform(input int id, input logic start_at_done);
    @(negedge clk);
    check(expect_at(0), $sformatf("run%0d t=0", id));
    start = 1'b1;
    for (int t = 1; t <= DONE_T; t++) begin
      @(negedge clk);
      check(expect_at(t), $sformatf("run%0d t=%0d", id, t));
      start = (t == DONE_T) ? start_at_done : 1'($urandom % 2);
    end
    @(negedge clk);
    check(expect_at(0), $sformatf("run%0d idle1", id));
    start = 1'b0;
    @(negedge clk);
    check(expect_at(0), $sformatf("run%0d idle2", id));
  endtask

  initial begin
    int cut;
    rst   = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    check('0, "reset");
    rst = 1'b1;
    repeat ($urandom_range(1, 4)) begin
      @(negedge clk);
      check('0, "idle_gap");
    end

    transform(1, 1'b0);
    transform(2, 1'b1);

    for (int g = 0; g < 3 * (DONE_T + 1); g++) begin
      @(negedge clk);
      check(expect_at(g % (DONE_T + 1)), $sformatf("b2b g=%0d", g));
      start = 1'b1;
    end
    @(negedge clk);
    check('0, "b2b end");
    start = 1'b0;
    @(negedge clk);
    check('0, "b2b idle");

    cut = N + 2 + (N / 2 + P) + int'($urandom_range(0, N / 2 - 1));
    start = 1'b1;
    for (int t = 1; t <= cut; t++) begin
      @(negedge clk);
      check(expect_at(t), $sformatf("pre_rst t=%0d", t));
      start = 1'($urandom % 2);
    end
    rst = 1'b0;
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b0;
    check('0, "rst_cycle");
    for (int i = 0; i < P + 3; i++) begin
      @(negedge clk);
      check('0, $sformatf("post_rst %0d", i));
    end

    transform(3, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
